// File: rtl/conv_window_scheduler_if.sv
// Scheduler bus: image-memory read port plus the 3x3 window bundle.
// master = scheduler, slave = memory / conv stage.
interface conv_window_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        win0, win1, win2;
  logic [7:0]        win3, win4, win5;
  logic [7:0]        win6, win7, win8;
  logic              win_valid;
  logic              conv_done;
  logic [ADDR_W-1:0] out_row;
  logic [ADDR_W-1:0] out_col;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output win0, win1, win2,
    output win3, win4, win5,
    output win6, win7, win8,
    output win_valid, out_row, out_col,
    input  conv_done
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  win0, win1, win2,
    input  win3, win4, win5,
    input  win6, win7, win8,
    input  win_valid, out_row, out_col,
    output conv_done
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Raster-order 3x3 window fetcher over a sync-read image memory.
// Ports: clk, reset (sync, active-low), start, bus (memory + window
// handshake), busy (scan in progress), pixel_end (scan done pulse).
module conv_window_scheduler #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  conv_window_scheduler_if.master bus,
  output logic busy,
  output logic pixel_end
);
  localparam logic [ADDR_W-1:0] W_A =
    ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_STEP =
    ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LAST_COL =
    ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] LAST_ROW =
    ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] ONE =
    ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT
  } state_t;

  state_t state, state_n;

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [3:0]        rd_k;
  logic [1:0]        kx;
  logic              cap_en;
  logic [3:0]        cap_k;
  logic [7:0]        win_q [9];
  logic              win_valid_q;
  logic [ADDR_W-1:0] row_q, col_q;
  logic [ADDR_W-1:0] row_n, col_n;

  logic last_win, consume;
  logic cap_last, issue_more;

  assign last_win   = (row_q == LAST_ROW) &&
                      (col_q == LAST_COL);
  assign consume    = win_valid_q && bus.conv_done;
  assign cap_last   = cap_en && (cap_k == 4'd8);
  // rd_en is only ever high in FETCH
  assign issue_more = rd_en_q && (rd_k != 4'd8);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == S_IDLE):
        if (start) state_n = S_FETCH;
      (state == S_FETCH):
        if (cap_last) state_n = S_PRESENT;
      (state == S_PRESENT):
        if (consume)
          state_n = last_win ? S_IDLE : S_FETCH;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    row_n = row_q;
    col_n = col_q + ONE;
    if (col_q == LAST_COL) begin
      col_n = '0;
      row_n = row_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_k        <= '0;
      kx          <= '0;
      cap_en      <= 1'b0;
      cap_k       <= '0;
      win_valid_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      busy        <= 1'b0;
      pixel_end   <= 1'b0;
      for (int i = 0; i < 9; i++)
        win_q[i] <= '0;
    end else begin
      rd_en_q     <= 1'b0;
      pixel_end   <= 1'b0;
      // memory returns data one cycle after the
      // strobe; capture one cycle after that
      cap_en      <= rd_en_q;
      cap_k       <= rd_k;
      if (cap_en) win_q[cap_k] <= bus.rd_data;
      win_valid_q <= (state_n == S_PRESENT);
      busy        <= (state_n != S_IDLE);
      unique case (1'b1)
        (state == S_IDLE && start): begin
          row_q     <= '0;
          col_q     <= '0;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
          rd_k      <= '0;
          kx        <= '0;
        end
        issue_more: begin
          rd_en_q <= 1'b1;
          rd_k    <= rd_k + 4'd1;
          kx      <= (kx == 2'd2) ? 2'd0 : kx + 2'd1;
          // step to next window row after kx==2
          rd_addr_q <= rd_addr_q +
            ((kx == 2'd2) ? ROW_STEP : ONE);
        end
        (consume && last_win): begin
          pixel_end <= 1'b1;
        end
        (consume && !last_win): begin
          row_q     <= row_n;
          col_q     <= col_n;
          rd_en_q   <= 1'b1;
          rd_addr_q <= row_n * W_A + col_n;
          rd_k      <= '0;
          kx        <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.win_valid = win_valid_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.win0      = win_q[0];
  assign bus.win1      = win_q[1];
  assign bus.win2      = win_q[2];
  assign bus.win3      = win_q[3];
  assign bus.win4      = win_q[4];
  assign bus.win5      = win_q[5];
  assign bus.win6      = win_q[6];
  assign bus.win7      = win_q[7];
  assign bus.win8      = win_q[8];
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler on a 5x4 image.
// Stimulus pushes expected reads/windows; monitors pop and compare.
module tb_conv_window_scheduler;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, pixel_end;
  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  logic spur_en = 1'b0;
  logic [7:0] mem_q = '0;
  int done_dly = 0;
  int errors = 0;
  int checks = 0;
  int pend_exp = 0;

  typedef struct packed {
    logic [AW-1:0]   row;
    logic [AW-1:0]   col;
    logic [8:0][7:0] pix;
  } win_t;

  win_t          win_q [$];
  logic [AW-1:0] addr_q [$];

  int base_t [6] = '{0, 1, 2, 5, 6, 7};
  int off_t  [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  conv_window_scheduler_if #(.ADDR_W(AW)) bus();

  conv_window_scheduler #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .pixel_end(pixel_end)
  );

  always #5 clk = ~clk;

  // image memory: ram[a] = a, one-cycle read
  always @(posedge clk)
    if (bus.rd_en) mem_q <= bus.rd_addr[7:0];
  assign bus.rd_data   = mem_q;
  assign bus.conv_done = resp_done | spur_done;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic push_scan();
    win_t w;
    for (int i = 0; i < 6; i++) begin
      w.row = AW'(i / 3);
      w.col = AW'(i % 3);
      for (int k = 0; k < 9; k++) begin
        w.pix[k] = 8'(base_t[i] + off_t[k]);
        addr_q.push_back(AW'(base_t[i] + off_t[k]));
      end
      win_q.push_back(w);
    end
    pend_exp++;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rd_en"}, bus.rd_en, 0);
    chk({nm, "_win_valid"}, bus.win_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_pixel_end"}, pixel_end, 0);
    chk({nm, "_rd_addr"}, bus.rd_addr, 0);
    chk({nm, "_row"}, bus.out_row, 0);
    chk({nm, "_col"}, bus.out_col, 0);
    chk({nm, "_wins"},
        |{bus.win0, bus.win1, bus.win2,
          bus.win3, bus.win4, bus.win5,
          bus.win6, bus.win7, bus.win8}, 0);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pixel_end && n < budget);
    chk("scan_end_seen", pixel_end, 1);
  endtask

  // conv stage model: consume each window after done_dly cycles
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.win_valid) begin
        repeat (done_dly) @(negedge clk);
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  // spurious conv_done while reads are in flight
  initial begin
    forever begin
      @(negedge clk);
      spur_done = spur_en && bus.rd_en;
    end
  end

  // monitor
  logic wv_prev = 1'b0;
  int   run = 0;
  win_t snap;

  always @(negedge clk) begin
    win_t cur;
    win_t exp_w;
    cur.row = bus.out_row;
    cur.col = bus.out_col;
    cur.pix = {bus.win8, bus.win7, bus.win6,
               bus.win5, bus.win4, bus.win3,
               bus.win2, bus.win1, bus.win0};
    if (!reset) begin
      run = 0;
      wv_prev = 1'b0;
    end else begin
      if (bus.rd_en) begin
        run++;
        if (addr_q.size() == 0)
          chk("rd_unexpected", 1, 0);
        else
          chk("rd_addr", bus.rd_addr,
              addr_q.pop_front());
      end else if (run != 0) begin
        chk("rd_burst_len", run, 9);
        run = 0;
      end
      if (bus.win_valid && !wv_prev) begin
        if (win_q.size() == 0) begin
          chk("win_unexpected", 1, 0);
        end else begin
          exp_w = win_q.pop_front();
          chk("out_row", cur.row, exp_w.row);
          chk("out_col", cur.col, exp_w.col);
          for (int k = 0; k < 9; k++)
            chk($sformatf("win%0d", k),
                cur.pix[k], exp_w.pix[k]);
          chk("busy_in_win", busy, 1);
        end
        snap = cur;
      end else if (bus.win_valid) begin
        chk("win_stable", cur == snap, 1);
        chk("rd_en_present", bus.rd_en, 0);
      end
      wv_prev = bus.win_valid;
    end
    if (pixel_end === 1'b1) begin
      chk("pixel_end_expected", pend_exp > 0, 1);
      chk("busy_fall", busy, 0);
      chk("end_row", bus.out_row, IMG_H - 3);
      chk("end_col", bus.out_col, IMG_W - 3);
      if (pend_exp > 0) pend_exp--;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_hold");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_rd_en", bus.rd_en, 0);
      chk("idle_busy", busy, 0);
    end

    // scan A: latency and full raster order
    @(posedge clk); #1;
    start = 1'b1;
    push_scan();
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cnt = 0;
    while (!bus.win_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("win_valid_latency", cnt, 10);
    wait_end(400);
    @(negedge clk);
    chk("busy_after_end", busy, 0);
    chk("row_hold", bus.out_row, 1);
    chk("col_hold", bus.out_col, 2);

    // scan B: conv_done stalled 20 cycles
    done_dly = 20;
    @(posedge clk); #1;
    start = 1'b1;
    push_scan();
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(1000);

    // scan C: back-to-back start on pixel_end,
    // spurious conv_done and start mid-scan
    start = 1'b1;
    push_scan();
    done_dly = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    spur_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    wait_end(400);
    spur_en = 1'b0;

    // scan D: reset during second window fetch
    @(posedge clk); #1;
    start = 1'b1;
    push_scan();
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (!bus.win_valid && cnt < 50) begin
      @(negedge clk); cnt++;
    end
    while (bus.win_valid && cnt < 100) begin
      @(negedge clk); cnt++;
    end
    while (!bus.rd_en && cnt < 100) begin
      @(negedge clk); cnt++;
    end
    chk("abort_in_fetch", bus.rd_en, 1);
    chk("abort_col", bus.out_col, 1);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    addr_q.delete();
    win_q.delete();
    pend_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("abort_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_rd", bus.rd_en, 0);
    end

    // scan E: restart from (0,0)
    @(posedge clk); #1;
    start = 1'b1;
    push_scan();
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(400);
    repeat (3) @(negedge clk);

    chk("addr_q_empty", addr_q.size(), 0);
    chk("win_q_empty", win_q.size(), 0);
    chk("pend_left", pend_exp, 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
